// File: rtl/seg_pkg.sv
// Shared constants for the two-digit 7-segment scan stage: segment patterns and slot encoding.
// Segment order {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [6:0] DIGIT_SEG [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic {
    SLOT_ONE = 1'b0,
    SLOT_TWO = 1'b1
  } slot_e;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Digit inputs from the BCD counter and multiplexed display outputs of bcd_seg_scan.
interface bcd_seg_scan_if;
  logic [3:0] in_ten;
  logic [3:0] in_one;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_start;
  logic       bcd_err;

  modport master (
    output in_ten, in_one,
    input  seg, an, frame_start, bcd_err
  );

  modport slave (
    input  in_ten, in_one,
    output seg, an, frame_start, bcd_err
  );
endinterface

// File: rtl/bcd_seg_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (bcd_i < 4'd10) seg_o = DIGIT_SEG[bcd_i];
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit common-anode scan driver with frame-atomic input latching and blanking.
// Optional leading-zero blanking of the tens digit: define BCD_SEG_SCAN_LZB_EN.
module bcd_seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic           clk,
  input  logic           reset,
  bcd_seg_scan_if.slave  bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  slot_e         sel_q, sel_d;
  logic [3:0]    sh_ten_q, sh_ten_d, sh_one_q, sh_one_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          fs_q, fs_d;
  logic          err_q, err_d;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic          wrap, boundary, blank;

  bcd_to_seg u_dec (
    .bcd_i (digit),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      sel_q    <= SLOT_ONE;
      sh_ten_q <= '0;
      sh_one_q <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= '1;
      fs_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      sh_ten_q <= sh_ten_d;
      sh_one_q <= sh_one_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fs_q     <= fs_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    boundary = wrap && (sel_q == SLOT_TWO);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    sel_d    = sel_q;
    if (wrap) sel_d = (sel_q == SLOT_ONE) ? SLOT_TWO : SLOT_ONE;
    // Inputs are sampled only when the tens slot hands back to the ones slot.
    sh_ten_d = boundary ? bus.in_ten : sh_ten_q;
    sh_one_d = boundary ? bus.in_one : sh_one_q;
    fs_d     = boundary;
    err_d    = err_q || (sh_ten_q > 4'd9) || (sh_one_q > 4'd9);

    digit = (sel_q == SLOT_TWO) ? sh_ten_q : sh_one_q;
    blank = (cnt_q < BLANK_END);
`ifdef BCD_SEG_SCAN_LZB_EN
    if ((sel_q == SLOT_TWO) && (sh_ten_q == 4'd0)) blank = 1'b1;
`else
    blank = blank;
`endif
    an_d  = '1;
    seg_d = SEG_OFF;
    if (!blank) begin
      an_d  = (sel_q == SLOT_TWO) ? 2'b01 : 2'b10;
      seg_d = dec_seg;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;
  assign bus.bcd_err     = err_q;

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream display stage for the two-digit BCD counter. Consumes the tens and ones digits and drives a two-digit, common-anode, multiplexed 7-segment display.
- Time-multiplexes the digits with a refresh counter and inserts anti-ghosting blanking at each slot start.
- Latches its inputs only at frame boundaries, so a display frame never mixes digits from two counter values.
- Flags non-BCD input codes.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; minimum 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_ten  input  4  tens BCD digit from the counter.
- in_one  input  4  ones BCD digit from the counter.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- an  output  2  digit enables, active-low; an[0] = ones, an[1] = tens.
- frame_start  output  1  one-cycle pulse on the cycle the shadow registers load.
- bcd_err  output  1  sticky flag: a latched digit was greater than 9.

Behaviour:
- Reset values (while reset=0): seg=7'h7F, an=2'b11, frame_start=0, bcd_err=0, refresh cnt=0, sel=0, sh_ten=0, sh_one=0.
- Refresh counter cnt, width clog2(REFRESH_DIV):
  - increments every cycle;
  - at REFRESH_DIV-1 it wraps to 0 and toggles sel.
- Slot mapping: sel=0 is the ones slot, sel=1 is the tens slot. Frame = ones slot followed by tens slot = 2*REFRESH_DIV cycles.
- Frame boundary: the edge on which cnt wraps while sel=1 (sel goes 1->0).
  - On that edge, sh_ten<=in_ten and sh_one<=in_one.
  - frame_start=1 for the following cycle.
  - Inputs are ignored at all other times.
- First frame after reset release: starts at cnt=0, sel=0, with shadow=00. The first input load happens at the first boundary, 2*REFRESH_DIV edges after release.
- seg and an are registered, one cycle of latency. On every edge they are computed from the pre-edge (cnt, sel, shadow):
  - cnt < BLANK_CYCLES: an=2'b11, seg=7'h7F.
  - otherwise: an drives the active low bit for the selected digit; seg = decode(selected shadow digit).
- Decode:
  - 0-9: standard patterns; for example 0 = 7'h40, 1 = 7'h79, 8 = 7'h00.
  - 10-15: dash (only g lit) = 7'h3F.
- bcd_err: set on the cycle after a load where sh_ten>9 or sh_one>9. It stays set until reset; valid later loads do not clear it.
- Both anodes are never active simultaneously; an=2'b00 is illegal in all states.
- Reset asserted mid-slot: all registers return to their reset values asynchronously. Outputs blank immediately, with no wait for a clock edge.

Optional Feature:
- Macro: BCD_SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined: during the tens slot, if sh_ten==0, an stays 2'b11 and seg=7'h7F for the whole slot. Example: value 07 shows only "7".
- Undefined: the tens digit always displays, so "07" shows as two digits.
- The ones digit is never blanked in either mode.

Decomposition:
- Package seg_pkg:
  - SEG_OFF=7'h7F, SEG_DASH=7'h3F;
  - a 10-entry digit-to-segment constant table;
  - slot enum {SLOT_ONE, SLOT_TWO}.
- Sub-module bcd_to_seg: pure combinational 4-bit to 7-bit decoder using seg_pkg; it handles the dash for codes 10-15.
- The top module holds the counter, sel, shadow registers, blanking logic and output registers.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1):
- Reset hold: reset=0 for 5 cycles with inputs 3/7 -> seg=7'h7F, an=2'b11, bcd_err=0, frame_start=0 throughout.
- Scan: release reset with in_ten=3, in_one=7.
  - First frame shows 0/0; frame_start pulses at cycle 8.
  - Next frame: an=2'b10 with seg=7'h78 ("7") for 3 cycles after 1 blank cycle, then an=2'b01 with seg=7'h30 ("3").
- Frame atomicity: change the inputs 5->6 in mid-frame -> displayed digits change only after the next frame_start; no frame mixes old and new digits.
- Invalid BCD: in_one=4'hC loaded -> ones slot shows seg=7'h3F; bcd_err=1 the cycle after the load and stays 1 after in_one returns to 2.
- Async reset mid-slot: drop reset with no clock edge while an=2'b10 -> an=2'b11 and seg=7'h7F immediately; after release the scan restarts at cnt=0, sel=0.
- With BCD_SEG_SCAN_LZB_EN defined, in_ten=0, in_one=9 -> an[1] never goes low; ones slot shows 7'h10.
